// File: rtl/eq_pkg.sv
// Shared EQ constants, FIR scheduler state encoding and the Q1.15 output saturation helper.
package eq_pkg;
    localparam int SAMPLE_W = 24;
    localparam int COEF_W   = 16;
    localparam int PROD_W   = 40;
    localparam int Q_SHIFT  = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_e;

    // acc is zero-extended by the caller, so bits above the real accumulator are always 0.
    function automatic logic [SAMPLE_W-1:0] sat_acc(input logic [63:0] acc);
        if ((acc >> (SAMPLE_W + Q_SHIFT)) != 64'd0)
            return {SAMPLE_W{1'b1}};
        return acc[SAMPLE_W+Q_SHIFT-1:Q_SHIFT];
    endfunction
endpackage

// File: rtl/fir_tap_scheduler_if.sv
// Sample stream, coefficient write port, multiplier operands/product and result of one FIR section.
interface fir_tap_scheduler_if #(
    parameter int TAPS = 8
);
    import eq_pkg::*;
    localparam int AW = $clog2(TAPS);

    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;
    logic                coef_we;
    logic [AW-1:0]       coef_addr;
    logic [COEF_W-1:0]   coef_data;
    logic [SAMPLE_W-1:0] mul_sample;
    logic [COEF_W-1:0]   mul_coef;
    logic                mul_start;
    logic [PROD_W-1:0]   mul_product;
    logic                mul_ready;
    logic [SAMPLE_W-1:0] result;
    logic                result_valid;

    modport master (
        input  sample, sample_valid, coef_we, coef_addr, coef_data, mul_product, mul_ready,
        output sample_ready, mul_sample, mul_coef, mul_start, result, result_valid
    );

    modport slave (
        output sample, sample_valid, coef_we, coef_addr, coef_data, mul_product, mul_ready,
        input  sample_ready, mul_sample, mul_coef, mul_start, result, result_valid
    );
endinterface

// File: rtl/fir_delay_line.sv
// Ring buffer of past samples: one write port, one combinational indexed read, synchronous clear.
module fir_delay_line #(
    parameter int DEPTH = 8,
    parameter int W     = eq_pkg::SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [DEPTH-1:0][W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fir_tap_scheduler.sv
// Drives the shared serial multiplier once per tap and accumulates one filtered sample per input.
module fir_tap_scheduler #(
    parameter int TAPS = 8
) (
    input logic                 i_clk,
    input logic                 i_rst,
    fir_tap_scheduler_if.master bus
);
    import eq_pkg::*;

    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = SAMPLE_W + COEF_W + AW;
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    fir_state_e state, state_nxt;

    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 tap;
    logic [AW-1:0]                 tap_inc;
    logic [AW-1:0]                 rd_idx;
    logic [ACC_W-1:0]              acc;
    logic [ACC_W-1:0]              acc_sum;
    logic [SAMPLE_W-1:0]           op_sample;
    logic [COEF_W-1:0]             op_coef;
    logic [SAMPLE_W-1:0]           result_q;
    logic [SAMPLE_W-1:0]           rd_data;
    logic [TAPS-1:0][COEF_W-1:0]   coef;
    logic                          accept;
    logic                          start;

    assign accept  = (state == ST_IDLE) && bus.sample_valid;
    assign tap_inc = tap + 1'b1;
    // Operands for the following tap are fetched while the current product lands.
    assign rd_idx  = wr_ptr - tap_inc;
    assign acc_sum = acc + ACC_W'(bus.mul_product);

    fir_delay_line #(
        .DEPTH (TAPS),
        .W     (SAMPLE_W)
    ) u_delay (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.sample),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE:  if (bus.sample_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: if (bus.mul_ready) begin
                start     = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (bus.mul_ready) state_nxt = (tap == LAST_TAP) ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            tap       <= '0;
            acc       <= '0;
            op_sample <= '0;
            op_coef   <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.sample_valid) begin
                    acc       <= '0;
                    tap       <= '0;
                    op_sample <= bus.sample;
                    op_coef   <= coef[0];
                end
                ST_WAIT: if (bus.mul_ready) begin
                    acc <= acc_sum;
                    tap <= tap_inc;
                    if (tap == LAST_TAP) begin
                        result_q <= sat_acc(64'(acc_sum));
                    end else begin
                        op_sample <= rd_data;
                        op_coef   <= coef[tap_inc];
                    end
                end
                ST_DONE: wr_ptr <= wr_ptr + 1'b1;
                default: ;
            endcase
        end
    end

    // Coefficients survive reset; writes outside IDLE are dropped so a running sample sees one bank.
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && bus.coef_we)
            coef[bus.coef_addr] <= bus.coef_data;
    end

    assign bus.sample_ready = (state == ST_IDLE);
    assign bus.mul_start    = start;
    assign bus.mul_sample   = op_sample;
    assign bus.mul_coef     = op_coef;
    assign bus.result       = result_q;
    assign bus.result_valid = (state == ST_DONE);
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Scoreboarded bench for fir_tap_scheduler with a 16-cycle serial multiplier model.
module tb_fir_tap_scheduler;
    import eq_pkg::*;

    localparam int TAPS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_tap_scheduler_if #(.TAPS(TAPS)) bus ();

    fir_tap_scheduler #(.TAPS(TAPS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Multiplier: busy 16 cycles after start, product held once ready returns.
    logic [4:0]        mcnt;
    logic [PROD_W-1:0] mprod;
    always @(posedge clk) begin
        if (rst) begin
            mcnt  <= '0;
            mprod <= '0;
        end else if (bus.mul_start && mcnt == 0) begin
            mcnt  <= 5'd16;
            mprod <= PROD_W'(bus.mul_sample) * PROD_W'(bus.mul_coef);
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1'b1;
        end
    end
    assign bus.mul_ready   = (mcnt == 0);
    assign bus.mul_product = mprod;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int starts = 0;
    int valids = 0;
    int rdy_low = 0;
    int last_valid_cyc = -1;
    int e0 = 0;
    logic [SAMPLE_W-1:0] exp_q[$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mul_start) starts++;
            if (!bus.sample_ready) rdy_low++;
            if (bus.result_valid) begin
                valids++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got 0x%0h with nothing expected", bus.result);
                end else begin
                    chk("result", 64'(bus.result), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_reset(int n);
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.coef_we = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(int k, logic [COEF_W-1:0] h);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'(k);
        bus.coef_data = h;
        @(negedge clk);
        bus.coef_we   = 1'b0;
    endtask

    task automatic send(logic [SAMPLE_W-1:0] x, bit has_exp, logic [SAMPLE_W-1:0] exp);
        int t = 0;
        while (!bus.sample_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!bus.sample_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=0, expected ready=1 within 400 cycles");
            return;
        end
        if (has_exp) exp_q.push_back(exp);
        bus.sample       = x;
        bus.sample_valid = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [SAMPLE_W-1:0] impulse_exp[8];
    int v_save;

    initial begin
        bus.sample = '0;
        bus.sample_valid = 1'b0;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        for (int i = 0; i < 8; i++) impulse_exp[i] = SAMPLE_W'(32 * (i + 1));

        // Reset state
        do_reset(3);
        chk("rst_ready", 64'(bus.sample_ready), 64'd1);
        chk("rst_start", 64'(bus.mul_start), 64'd0);
        chk("rst_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_mul_sample", 64'(bus.mul_sample), 64'd0);
        chk("rst_mul_coef", 64'(bus.mul_coef), 64'd0);

        // Impulse response through ramp coefficients
        for (int k = 0; k < 8; k++) write_coef(k, COEF_W'(32'h1000 * (k + 1)));
        send(24'h000100, 1'b1, impulse_exp[0]);
        for (int i = 1; i < 8; i++) send(24'h000000, 1'b1, impulse_exp[i]);
        drain();

        // Single-sample latency, start pulse count, ready-low span
        starts = 0; valids = 0; rdy_low = 0;
        send(24'h000800, 1'b1, 24'h000100);
        drain();
        chk("lat_valid_cycle", 64'(last_valid_cyc), 64'(e0 + 144));
        chk("lat_valid_count", 64'(valids), 64'd1);
        chk("lat_start_count", 64'(starts), 64'd8);
        chk("lat_ready_low", 64'(rdy_low), 64'd145);

        // Full-scale saturation
        do_reset(2);
        for (int k = 0; k < 8; k++) write_coef(k, 16'hFFFF);
        for (int i = 0; i < 8; i++) send(24'hFFFFFF, 1'b1, 24'hFFFFFF);
        drain();

        // Just below and just above the saturation threshold
        do_reset(2);
        for (int k = 0; k < 8; k++) write_coef(k, 16'h7FFF);
        send(24'hFFFFFF, 1'b1, 24'hFFFDFF);
        send(24'hFFFFFF, 1'b1, 24'hFFFFFF);
        drain();

        // Coefficient write while busy is dropped
        do_reset(2);
        for (int k = 0; k < 8; k++) write_coef(k, COEF_W'(32'h1000 * (k + 1)));
        send(24'h000100, 1'b1, 24'h000020);
        repeat (20) @(negedge clk);
        write_coef(0, 16'h0000);
        send(24'h000100, 1'b1, 24'h000060);
        drain();

        // Reset during tap 3 abandons the sample
        do_reset(2);
        starts = 0;
        v_save = valids;
        send(24'h000100, 1'b0, '0);
        begin
            int t = 0;
            while (starts < 4 && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        chk("abort_reached_tap3", 64'(starts >= 4), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idle_ready", 64'(bus.sample_ready), 64'd1);
        chk("abort_valid_low", 64'(bus.result_valid), 64'd0);
        repeat (170) @(negedge clk);
        chk("abort_no_result", 64'(valids), 64'(v_save));
        send(24'h000100, 1'b1, impulse_exp[0]);
        for (int i = 1; i < 8; i++) send(24'h000000, 1'b1, impulse_exp[i]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
